dp_rrsel4: RTL

DP_RRSEL4 -- requirements
Module: dp_rrsel4

---
 rtl/dp_rrsel4_pkg.sv | 10 +
 rtl/dp_mux4ds.sv | 24 ++
 rtl/dp_rrsel4.sv | 103 ++++++++++
 3 files changed

// File: rtl/dp_rrsel4_pkg.sv
// Shared constants and types for the dp_rrsel4 round-robin selector.
// This file is imported by the top-level block.
package dp_rrsel4_pkg;

  localparam int         NUM_SRC = 4;
  localparam logic [1:0] PTR_RST = 2'd3;  // last winner = 3, so source 0 is searched first

  typedef logic [NUM_SRC-1:0] src_vec_t;

endpackage : dp_rrsel4_pkg

// File: rtl/dp_mux4ds.sv
// Four-way AND-OR data mux driven by one-cold, active-low selects.
// When all selects are high, the output is zero.
module dp_mux4ds #(
  parameter int SIZE = 1
) (
  input  logic [SIZE-1:0] in0,
  input  logic [SIZE-1:0] in1,
  input  logic [SIZE-1:0] in2,
  input  logic [SIZE-1:0] in3,
  input  logic            sel0_l,
  input  logic            sel1_l,
  input  logic            sel2_l,
  input  logic            sel3_l,
  output logic [SIZE-1:0] dout
);

  always_comb begin
    dout = ({SIZE{~sel0_l}} & in0)
         | ({SIZE{~sel1_l}} & in1)
         | ({SIZE{~sel2_l}} & in2)
         | ({SIZE{~sel3_l}} & in3);
  end

endmodule : dp_mux4ds

// File: rtl/dp_rrsel4.sv
// Four-source round-robin selector with a single registered output slot.
// The grant is combinational; dout and out_vld are registered one cycle after the grant.
module dp_rrsel4
  import dp_rrsel4_pkg::*;
#(
  parameter int SIZE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0]      req,
  input  logic [SIZE-1:0] in0,
  input  logic [SIZE-1:0] in1,
  input  logic [SIZE-1:0] in2,
  input  logic [SIZE-1:0] in3,
  output logic [3:0]      gnt,
  output logic            sel0_l,
  output logic            sel1_l,
  output logic            sel2_l,
  output logic            sel3_l,
  output logic            out_vld,
  input  logic            out_rdy,
  output logic [SIZE-1:0] dout
);

  logic [1:0]      ptr;
  logic            load_slot;
  logic [SIZE-1:0] mux_dout;
  logic [3:0]      sel_l;

  // Rotate req so the search starts at last+1, isolate the lowest set bit,
  // then rotate the result back to source positions.
  function automatic src_vec_t rr_pick(input src_vec_t r, input logic [1:0] last);
    logic [2:0] sh;
    logic [7:0] dbl;
    src_vec_t   rot;
    src_vec_t   hit;
    logic [7:0] back;
    sh   = {1'b0, last} + 3'd1;
    dbl  = {r, r} >> sh;
    rot  = dbl[3:0];
    hit  = rot & (~rot + 4'd1);
    back = {hit, hit} << sh;
    return back[7:4];
  endfunction

  function automatic logic [1:0] onehot_idx(input src_vec_t v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  assign load_slot = ~out_vld | out_rdy;

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    gnt = 4'b0000;
    if (rst_n && load_slot) begin
      gnt = rr_pick(req, ptr);
    end
  end

  assign sel_l  = ~gnt;
  assign sel0_l = sel_l[0];
  assign sel1_l = sel_l[1];
  assign sel2_l = sel_l[2];
  assign sel3_l = sel_l[3];

  dp_mux4ds #(
    .SIZE (SIZE)
  ) u_mux (
    .in0    (in0),
    .in1    (in1),
    .in2    (in2),
    .in3    (in3),
    .sel0_l (sel0_l),
    .sel1_l (sel1_l),
    .sel2_l (sel2_l),
    .sel3_l (sel3_l),
    .dout   (mux_dout)
  );

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr     <= PTR_RST;
      out_vld <= 1'b0;
      dout    <= '0;
    end else if (|gnt) begin
      ptr     <= onehot_idx(gnt);
      out_vld <= 1'b1;
      dout    <= mux_dout;
    end else if (out_vld && out_rdy) begin
      out_vld <= 1'b0;
    end
  end

  sel_one_cold_a : assert property (@(posedge clk) disable iff (!rst_n)
    ($onehot(~sel_l) || (sel_l == 4'b1111)));

endmodule : dp_rrsel4
